// File: rtl/stream_byte_packer.sv
// Packs a left-aligned byte stream with partial beats into dense full-width beats.
// A residual of up to BYTES-1 bytes is carried between input beats.
module stream_byte_packer #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned BYTES     = WIDTH / 8,
  parameter int unsigned CNT_WIDTH = $clog2(BYTES) + 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [WIDTH-1:0]     s_tdata,
  input  logic [BYTES-1:0]     s_tkeep,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [WIDTH-1:0]     m_tdata,
  output logic [BYTES-1:0]     m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [CNT_WIDTH-2:0] o_fill
);

  localparam int unsigned FW = CNT_WIDTH - 1;
  // One extra bit so fill + n (up to 2*BYTES-1) never overflows.
  localparam int unsigned SW = CNT_WIDTH + 1;
  localparam logic [SW-1:0] BytesC = SW'(BYTES);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e             state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [WIDTH-1:0]   resid_q, resid_d;
  logic [WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [BYTES-1:0]   m_tkeep_q, m_tkeep_d;
  logic               m_tlast_q, m_tlast_d;
  logic               m_tvalid_q, m_tvalid_d;

  logic               out_free;
  logic               accept;
  logic [SW-1:0]      in_cnt;
  logic [SW-1:0]      cnt;
  logic [WIDTH-1:0]   in_masked;
  logic [2*WIDTH-1:0] merged;

  function automatic logic [BYTES-1:0] low_mask(input logic [SW-1:0] n);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      m[i] = (SW'(i) < n);
    end
    return m;
  endfunction

  assign out_free = !m_tvalid_q || m_tready;
  assign s_tready = !areset && (state_q == StRun) && out_free;
  assign accept   = s_tvalid && s_tready;

  always_comb begin
    in_cnt    = '0;
    in_masked = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      in_cnt             = in_cnt + SW'(s_tkeep[i]);
      in_masked[8*i +: 8] = s_tdata[8*i +: 8] & {8{s_tkeep[i]}};
    end
  end

  assign cnt    = SW'(fill_q) + in_cnt;
  // Residual bytes above fill are always zero, so OR implements the merge.
  assign merged = {{WIDTH{1'b0}}, resid_q} | ({{WIDTH{1'b0}}, in_masked} << {fill_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    resid_d    = resid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;

    if (out_free) begin
      m_tvalid_d = 1'b0;
    end

    if (state_q == StFlush) begin
      if (out_free) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = resid_q;
        m_tkeep_d  = low_mask(SW'(fill_q));
        m_tlast_d  = 1'b1;
        fill_d     = '0;
        resid_d    = '0;
        state_d    = StRun;
      end
    end else if (accept) begin
      if (!s_tlast) begin
        if (cnt < BytesC) begin
          resid_d = merged[WIDTH-1:0];
          fill_d  = FW'(cnt);
        end else begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = merged[WIDTH-1:0];
          m_tkeep_d  = '1;
          m_tlast_d  = 1'b0;
          resid_d    = merged[2*WIDTH-1:WIDTH];
          fill_d     = FW'(cnt - BytesC);
        end
      end else if (cnt <= BytesC) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = merged[WIDTH-1:0];
        m_tkeep_d  = low_mask(cnt);
        m_tlast_d  = 1'b1;
        resid_d    = '0;
        fill_d     = '0;
      end else begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = merged[WIDTH-1:0];
        m_tkeep_d  = '1;
        m_tlast_d  = 1'b0;
        resid_d    = merged[2*WIDTH-1:WIDTH];
        fill_d     = FW'(cnt - BytesC);
        state_d    = StFlush;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StRun;
      fill_q     <= '0;
      resid_q    <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      resid_q    <= resid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
  assign o_fill   = fill_q;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Scoreboard bench for stream_byte_packer: a byte-queue model pushes expected beats on each
// accepted input beat, and a monitor pops and compares on every output handshake.
module tb_stream_byte_packer;

  localparam int W = 512;
  localparam int B = 64;
  localparam int CW = 7;

  typedef struct {
    logic [W-1:0] data;
    logic [B-1:0] keep;
    logic         last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [W-1:0]  s_tdata = '0;
  logic [B-1:0]  s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic [B-1:0]  m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [CW-2:0] o_fill;

  int   n_total = 0;
  int   n_pass = 0;
  bit   rand_rdy = 1'b0;
  bit   force_rdy = 1'b1;
  beat_t      exp_q[$];
  logic [7:0] model_q[$];

  stream_byte_packer #(.WIDTH(W)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .o_fill  (o_fill)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (s_tvalid) begin
      assert ((s_tkeep & (s_tkeep + 1'b1)) == '0) else $error("non-contiguous s_tkeep");
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
    else n_pass++;
  endtask

  function automatic logic [B-1:0] mask_of(input int n);
    logic [B-1:0] m;
    m = '0;
    for (int i = 0; i < B; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Pop up to 64 bytes from the model queue into one expected beat.
  task automatic emit(input int cnt, input logic last);
    beat_t bt;
    bt.data = '0;
    for (int i = 0; i < cnt; i++) bt.data[8*i +: 8] = model_q.pop_front();
    bt.keep = mask_of(cnt);
    bt.last = last;
    exp_q.push_back(bt);
  endtask

  task automatic model_accept(input logic [W-1:0] data, input int n, input bit last);
    for (int i = 0; i < n; i++) model_q.push_back(data[8*i +: 8]);
    if (!last) begin
      if (model_q.size() >= B) emit(B, 1'b0);
    end else begin
      if (model_q.size() > B) emit(B, 1'b0);
      emit(model_q.size(), 1'b1);
    end
  endtask

  // Drive one beat (called #1 after a posedge); returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] data, input int n, input bit last);
    logic [W-1:0] md;
    bit acc;
    int t;
    md = '0;
    for (int i = 0; i < n; i++) md[8*i +: 8] = data[8*i +: 8];
    s_tdata = md;
    s_tkeep = mask_of(n);
    s_tlast = last;
    s_tvalid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge aclk);
      if (s_tready) begin
        acc = 1'b1;
        model_accept(md, n, last);
      end
      @(posedge aclk);
      #1;
      t++;
    end
    s_tvalid = 1'b0;
    if (!acc) chk("send_timeout", W'(0), W'(1));
  endtask

  function automatic logic [W-1:0] seq(input int start);
    logic [W-1:0] d;
    for (int i = 0; i < B; i++) d[8*i +: 8] = 8'(start + i);
    return d;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge aclk);
      #1;
      t++;
    end
    chk("drain", W'(exp_q.size()), W'(0));
  endtask

  // m_tready driver; #2 lets the stimulus change force_rdy at #1 of the same cycle.
  initial begin
    forever begin
      @(posedge aclk);
      #2;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end
  end

  // Monitor: compares on handshakes and checks hold-stability under backpressure.
  initial begin
    beat_t bt;
    logic  stalled;
    logic [W-1:0] h_data;
    logic [B-1:0] h_keep;
    logic  h_last;
    stalled = 1'b0;
    h_data = '0;
    h_keep = '0;
    h_last = 1'b0;
    forever begin
      @(negedge aclk);
      if (stalled && m_tvalid === 1'b1 && !areset) begin
        chk("stall_data", m_tdata, h_data);
        chk("stall_keep", W'(m_tkeep), W'(h_keep));
        chk("stall_last", W'(m_tlast), W'(h_last));
      end
      if (m_tvalid === 1'b1 && m_tready && !areset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", W'(1), W'(0));
        end else begin
          bt = exp_q.pop_front();
          chk("out_data", m_tdata, bt.data);
          chk("out_keep", W'(m_tkeep), W'(bt.keep));
          chk("out_last", W'(m_tlast), W'(bt.last));
        end
      end
      stalled = (m_tvalid === 1'b1) && !m_tready && !areset;
      h_data = m_tdata;
      h_keep = m_tkeep;
      h_last = m_tlast;
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("reset_s_tready", W'(s_tready), W'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("reset_m_tvalid", W'(m_tvalid), W'(0));
    chk("reset_m_tkeep", W'(m_tkeep), W'(0));
    chk("reset_fill", W'(o_fill), W'(0));
    chk("reset_ready_run", W'(s_tready), W'(1));
    @(posedge aclk);
    #1;

    // Four full beats pass through unchanged with 1-cycle latency
    for (int b = 0; b < 4; b++) begin
      send(seq(b * 64), 64, b == 3);
      chk("full_fill", W'(o_fill), W'(0));
      chk("full_latency", W'(m_tvalid), W'(1));
    end
    drain();

    // 40,40,40 -> full beat then 56-byte last beat, no flush
    send(seq(0), 40, 1'b0);
    chk("fill40", W'(o_fill), W'(40));
    send(seq(40), 40, 1'b0);
    chk("fill16", W'(o_fill), W'(16));
    send(seq(80), 40, 1'b1);
    chk("fill0", W'(o_fill), W'(0));
    chk("no_flush_ready", W'(s_tready), W'(1));
    drain();

    // 60,60 -> full beat, then a single-cycle flush bubble
    send(seq(0), 60, 1'b0);
    send(seq(60), 60, 1'b1);
    @(negedge aclk);
    chk("flush_ready_low", W'(s_tready), W'(0));
    chk("flush_fill", W'(o_fill), W'(56));
    @(negedge aclk);
    chk("flush_ready_back", W'(s_tready), W'(1));
    chk("flush_fill_done", W'(o_fill), W'(0));
    @(posedge aclk);
    #1;
    drain();

    // Empty last beat and short single-beat packet
    send(seq(7), 0, 1'b1);
    send(seq(200), 10, 1'b1);
    drain();

    // Random packets under random backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) send(rnd_data(), $urandom_range(0, 64), b == nb - 1);
    end
    rand_rdy = 1'b0;
    force_rdy = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    drain();

    // Mid-packet reset with fill=30 and a stalled output beat
    send(seq(0), 50, 1'b0);
    force_rdy = 1'b0;
    send(seq(50), 44, 1'b0);
    chk("pre_reset_fill", W'(o_fill), W'(30));
    chk("pre_reset_valid", W'(m_tvalid), W'(1));
    areset = 1'b1;
    exp_q.delete();
    model_q.delete();
    @(negedge aclk);
    chk("in_reset_ready", W'(s_tready), W'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    force_rdy = 1'b1;
    @(negedge aclk);
    chk("post_reset_valid", W'(m_tvalid), W'(0));
    chk("post_reset_fill", W'(o_fill), W'(0));
    chk("post_reset_ready", W'(s_tready), W'(1));
    @(posedge aclk);
    #1;
    send(seq(100), 64, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_byte_packer.md
Name: stream_byte_packer

Overview:
- Sits in the compression datapath, upstream of the output shifter/writer.
- Compacts a byte stream whose beats carry 0..BYTES valid bytes, left-aligned with a contiguous tkeep, into dense full-width beats.
- Only the final beat of a packet may be partial.
- Holds a residual of up to BYTES-1 bytes between beats and shifts each incoming beat by the current fill level.

Parameters:
- WIDTH, 512, data width in bits; multiple of 8.
- BYTES, WIDTH/8, bytes per beat.
- CNT_WIDTH, $clog2(BYTES)+1, width of byte-count values (0..BYTES).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_tdata  in  WIDTH  input bytes; byte k at bits [8k+7:8k].
- s_tkeep  in  BYTES  contiguous low mask (2^n-1, n=0..BYTES).
- s_tlast  in  1  end of packet.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  WIDTH  packed output.
- m_tkeep  out  BYTES  all ones except on the final beat of a packet.
- m_tlast  out  1  end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- o_fill  out  CNT_WIDTH-1  current residual byte count (debug/status).

Behaviour:
- Reset (synchronous, areset=1 at a rising edge):
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
  - Residual count=0, o_fill=0, state=RUN.
  - s_tready=0 during the reset cycle.
  - Any packet in flight is discarded with no flush.
- Output register:
  - Single register stage; the register is "free" when m_tvalid=0 or m_tready=1.
  - m_* hold stable while m_tvalid=1 and m_tready=0.
- States: RUN and FLUSH.
- s_tready = (state==RUN) and output register free. It is registered-state derived only and never depends on s_tvalid.
- Accept = s_tvalid & s_tready. On accept, with n = popcount(s_tkeep), f = fill, c = f + n:
  - Merge: merged byte i = residual byte i for i<f, else s_tdata byte (i-f). This is the internal shift by f bytes, computed over a 2*BYTES-byte window.
  - c < BYTES, s_tlast=0: no output; residual=merged, fill=c.
  - c >= BYTES, s_tlast=0: emit merged bytes [0..BYTES-1], tkeep all ones, tlast=0; residual = merged bytes [BYTES..c-1] moved to position 0; fill = c-BYTES.
  - s_tlast=1, c <= BYTES: emit merged bytes [0..c-1], tkeep=2^c-1, tlast=1; fill=0.
  - s_tlast=1, c == 0: emit beat with tkeep=0, tdata=0, tlast=1, so the packet boundary is always forwarded.
  - s_tlast=1, c > BYTES: emit full beat, tlast=0; residual = c-BYTES bytes; go to FLUSH.
- FLUSH: s_tready=0. When the output register is free, emit the residual with tkeep=2^fill-1 and tlast=1; fill=0; go to RUN. FLUSH lasts at least 1 cycle.
- Latency: an accepted beat that produces output appears on m_* the next cycle.
- Throughput: 1 beat/cycle sustained, except the one FLUSH bubble per packet whose final merge exceeds BYTES.
- Unused residual and tdata bytes beyond tkeep are driven 0.
- Boundary rules:
  - A non-contiguous s_tkeep is a protocol violation; behaviour is unspecified, and the bench asserts contiguity on input.
  - fill never reaches BYTES; it wraps to c-BYTES.
  - Packets are independent: fill is always 0 at the start of a packet.
  - s_tvalid with s_tready=0 leaves all state unchanged.
  - Input may be held valid across backpressure.

Test Plan:
- Reset, then 4 full beats (tkeep all ones, last on the 4th) -> 4 output beats identical to input, 1-cycle latency, final tlast=1, fill stays 0.
- Beats of n=40, 40, 40 (last) -> out beat0 = bytes 0..63, tlast=0; beat1 = bytes 64..119, tkeep=2^56-1, tlast=1; no FLUSH; fill sequence 40 -> 16 -> 0.
- Beats n=60, 60 (last) -> full beat (bytes 0..63), then FLUSH beat with bytes 64..119, tkeep=2^56-1, tlast=1; s_tready=0 for exactly the FLUSH cycle.
- Single beat n=0 with tlast -> one beat, tkeep=0, tlast=1. Single beat n=10, tlast -> tkeep=0x3FF, tlast=1.
- Random m_tready (50%) over 1000 random packets with random contiguous tkeep -> byte-exact match with a scoreboard; m_* stable while stalled; only final beats are partial.
- areset asserted mid-packet with fill=30 and m_tvalid=1 -> next cycle m_tvalid=0, o_fill=0, state RUN. A new packet of n=64 then passes unchanged.
